// File: rtl/initiator_port_if.sv
// Initiator port bundle: initiator-core request/response signals plus the
// serial bus toward arbiter/target.
//   master : view of initiator_port (drives init_ready/done/err/rdata*, bus_req,
//            bus_data_out*, bus_mode, bus_rw)
//   slave  : view of the environment (initiator core + arbiter + target)
// Widths must match the parameters of the initiator_port it is bound to.
interface initiator_port_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  init_req;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic [DATA_WIDTH-1:0] init_wdata;
  logic                  init_rw;
  logic                  init_ready;
  logic                  init_done;
  logic                  init_err;
  logic [DATA_WIDTH-1:0] init_rdata;
  logic                  init_rdata_valid;
  logic                  bus_req;
  logic                  bus_grant;
  logic                  bus_data_out;
  logic                  bus_data_out_valid;
  logic                  bus_mode;
  logic                  bus_rw;
  logic                  bus_data_in;
  logic                  bus_data_in_valid;
  logic                  bus_target_ready;
  logic                  bus_target_ack;

  modport master (
    input  init_req, init_addr, init_wdata, init_rw,
           bus_grant, bus_data_in, bus_data_in_valid, bus_target_ready, bus_target_ack,
    output init_ready, init_done, init_err, init_rdata, init_rdata_valid,
           bus_req, bus_data_out, bus_data_out_valid, bus_mode, bus_rw
  );

  modport slave (
    output init_req, init_addr, init_wdata, init_rw,
           bus_grant, bus_data_in, bus_data_in_valid, bus_target_ready, bus_target_ack,
    input  init_ready, init_done, init_err, init_rdata, init_rdata_valid,
           bus_req, bus_data_out, bus_data_out_valid, bus_mode, bus_rw
  );
endinterface

// File: rtl/initiator_port.sv
// Initiator-side serial bus port. Accepts one parallel read/write request,
// requests the bus, shifts the address (and write data) out LSB first on a
// single bit, then waits for target ack / serial read data, or times out.
// Ports:
//   clk, rst_n : clock (posedge), asynchronous active-low reset
//   p          : initiator_port_if.master -- init_* request/response and
//                bus_* serial signals. All outputs registered except
//                init_ready, which is a decode of the IDLE state.
module initiator_port #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 1024
) (
  input logic              clk,
  input logic              rst_n,
  initiator_port_if.master p
);
  localparam int SW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW = $clog2(SW) + 1;
  localparam int RW = $clog2(DATA_WIDTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, REQ, ADDR, GAP, WDATA, WAIT, DONE} state_t;
  state_t state, state_nx;

  logic [SW-1:0]         tx_sh;    // remaining bits of the field being sent
  logic [DATA_WIDTH-1:0] wd_q;
  logic                  rw_q;
  logic [CW-1:0]         bit_cnt;
  logic [RW-1:0]         rx_cnt, rx_nx;
  logic [DATA_WIDTH-1:0] cap, cap_nx;
  logic [TW-1:0]         tcnt;
  logic                  ack_seen, rd_take, exit_ok, to_hit;

  logic                  busy_nx, rw_nx, dv_nx, mode_nx, dout_nx;
  logic                  done_nx, err_nx, rvalid_nx;
  logic [DATA_WIDTH-1:0] rdata_nx;

  // WAIT-phase evaluation. The current cycle's read bit and ack both count,
  // so a final bit arriving together with ack completes in that cycle.
  always_comb begin
    rd_take = (state == WAIT) && !rw_q && p.bus_data_in_valid &&
              (rx_cnt != RW'(DATA_WIDTH));
    // LSB-first capture: shift right, new bit enters at the MSB
    cap_nx  = rd_take ? ((cap >> 1) | (DATA_WIDTH'(p.bus_data_in) << (DATA_WIDTH - 1))) : cap;
    rx_nx   = rd_take ? rx_cnt + 1'b1 : rx_cnt;
    exit_ok = (ack_seen || p.bus_target_ack) && (rw_q || rx_nx == RW'(DATA_WIDTH));
    to_hit  = (state == WAIT) && !exit_ok && (tcnt == TW'(TIMEOUT - 1));
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (p.init_req) state_nx = REQ;
      REQ:     if (p.bus_grant && p.bus_target_ready) state_nx = ADDR;
      ADDR:    if (bit_cnt == CW'(ADDR_WIDTH - 1)) state_nx = rw_q ? GAP : WAIT;
      GAP:     state_nx = WDATA;
      WDATA:   if (bit_cnt == CW'(DATA_WIDTH - 1)) state_nx = WAIT;
      WAIT:    if (exit_ok || to_hit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // datapath: request latch, shifter, counters, ack tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sh    <= '0;
      wd_q     <= '0;
      rw_q     <= 1'b0;
      bit_cnt  <= '0;
      rx_cnt   <= '0;
      cap      <= '0;
      tcnt     <= '0;
      ack_seen <= 1'b0;
    end else begin
      if (state == IDLE && p.init_req) begin
        tx_sh <= SW'(p.init_addr);
        wd_q  <= p.init_wdata;
        rw_q  <= p.init_rw;
      end else if (state_nx == GAP) begin
        tx_sh <= SW'(wd_q);
      end else if (state_nx == ADDR || state_nx == WDATA) begin
        tx_sh <= tx_sh >> 1;  // bit 0 goes out on this edge
      end

      bit_cnt <= (state_nx == state && (state == ADDR || state == WDATA)) ?
                 bit_cnt + 1'b1 : '0;
      tcnt    <= (state == WAIT) ? tcnt + 1'b1 : '0;

      if (state == IDLE) begin
        rx_cnt   <= '0;
        cap      <= '0;
        ack_seen <= 1'b0;
      end else begin
        rx_cnt <= rx_nx;
        cap    <= cap_nx;
        if (state inside {ADDR, GAP, WDATA, WAIT} && p.bus_target_ack) ack_seen <= 1'b1;
      end
    end
  end

  // next values of the registered outputs, decoded from the upcoming state
  always_comb begin
    busy_nx   = state_nx inside {REQ, ADDR, GAP, WDATA, WAIT};
    rw_nx     = busy_nx && ((state == IDLE) ? p.init_rw : rw_q);
    dv_nx     = (state_nx == ADDR) || (state_nx == WDATA);
    mode_nx   = (state_nx == WDATA);
    dout_nx   = dv_nx && tx_sh[0];
    done_nx   = (state_nx == DONE);
    err_nx    = to_hit;
    rvalid_nx = done_nx && !to_hit && !rw_q;
    rdata_nx  = rvalid_nx ? cap_nx : p.init_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p.bus_req            <= 1'b0;
      p.bus_rw             <= 1'b0;
      p.bus_data_out_valid <= 1'b0;
      p.bus_mode           <= 1'b0;
      p.bus_data_out       <= 1'b0;
      p.init_done          <= 1'b0;
      p.init_err           <= 1'b0;
      p.init_rdata_valid   <= 1'b0;
      p.init_rdata         <= '0;
    end else begin
      p.bus_req            <= busy_nx;
      p.bus_rw             <= rw_nx;
      p.bus_data_out_valid <= dv_nx;
      p.bus_mode           <= mode_nx;
      p.bus_data_out       <= dout_nx;
      p.init_done          <= done_nx;
      p.init_err           <= err_nx;
      p.init_rdata_valid   <= rvalid_nx;
      p.init_rdata         <= rdata_nx;
    end
  end

  assign p.init_ready = (state == IDLE);
endmodule

// File: tb/tb_initiator_port.sv
// Self-checking bench for initiator_port: directed table of transactions,
// reset sequences, then randomized transactions. Per-cycle expectations come
// from a transaction-level model (phase windows and done cycle computed by
// arithmetic from the request, grant cycle, ack cycle and read-valid mask).
module tb_initiator_port;
  localparam int AW = 16, DW = 8, TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  initiator_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  initiator_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .p(bus));

  // g: first cycle (0 = cycle after accept) with grant&&target_ready high
  // ack_c: cycle with ack high (-1 none); vmask bit o: read bit valid at WAIT+o
  typedef struct {
    logic [15:0] addr; logic [7:0] wd; logic rw; int g; bit gdrop; int ack_c;
    logic [31:0] vmask; bit junk; logic [7:0] rd;
    int exp_d; bit exp_err; logic [7:0] exp_rdata;
  } txn_t;

  int checks = 0, errors = 0;
  logic [7:0] mdl_rdata = 8'h00;
  txn_t tbl[8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // {ready, req, rw, dv, mode, dout, done, err, rvalid}
  function automatic logic [8:0] cur_vec();
    return {bus.init_ready, bus.bus_req, bus.bus_rw, bus.bus_data_out_valid, bus.bus_mode,
            bus.bus_data_out, bus.init_done, bus.init_err, bus.init_rdata_valid};
  endfunction

  function automatic int wait_start(input txn_t t);
    return t.g + 1 + AW + (t.rw ? DW + 1 : 0);
  endfunction

  // Done cycle: first WAIT cycle meeting the completion rule, +1; else timeout.
  function automatic void predict(input txn_t t, output int d, output bit to);
    int w, nb; bit ack_ok;
    w = wait_start(t);
    to = 1'b0;
    for (int c = w; c < w + TO; c++) begin
      ack_ok = (t.ack_c >= t.g + 1) && (t.ack_c <= c);
      nb = $countones(t.vmask & ((32'd2 << (c - w)) - 32'd1));
      if (ack_ok && (t.rw || nb >= DW)) begin
        d = c + 1;
        return;
      end
    end
    d = w + TO;
    to = 1'b1;
  endfunction

  function automatic logic [8:0] exp_vec(input txn_t t, input int c, input int d, input bit to);
    logic [8:0] v;
    v = '0;
    if (c > d) v[8] = 1'b1;
    else if (c == d) begin
      v[2] = 1'b1; v[1] = to; v[0] = !t.rw && !to;
    end else begin
      v[7] = 1'b1; v[6] = t.rw;
      if (c >= t.g + 1 && c <= t.g + AW) begin
        v[5] = 1'b1; v[3] = ((t.addr >> (c - t.g - 1)) & 16'd1) != 0;
      end else if (t.rw && c >= t.g + AW + 2 && c <= t.g + AW + 1 + DW) begin
        v[5] = 1'b1; v[4] = 1'b1; v[3] = ((t.wd >> (c - t.g - AW - 2)) & 8'd1) != 0;
      end
    end
    return v;
  endfunction

  task automatic run_txn(input txn_t t, output int d_obs, output logic err_obs,
                         output logic [7:0] rd_obs);
    int d, w, kk; bit to; logic [7:0] exp_rd;
    predict(t, d, to);
    w = wait_start(t);
    d_obs = -1; err_obs = 1'b0; rd_obs = 8'h00; kk = 0;
    @(negedge clk);
    chk("ready_before_req", 64'(bus.init_ready), 64'd1);
    bus.init_req = 1'b1; bus.init_addr = t.addr; bus.init_wdata = t.wd; bus.init_rw = t.rw;
    @(negedge clk);
    // scramble request inputs: the port must have latched them
    bus.init_req = 1'b0; bus.init_addr = 16'($urandom);
    bus.init_wdata = 8'($urandom); bus.init_rw = 1'($urandom);
    for (int c = 0; c <= d + 1; c++) begin
      if (c > 0) @(negedge clk);
      if (bus.init_done && d_obs < 0) begin
        d_obs = c; err_obs = bus.init_err; rd_obs = bus.init_rdata;
      end
      chk($sformatf("cycle%0d_outputs", c), 64'(cur_vec()), 64'(exp_vec(t, c, d, to)));
      if (c == d) begin
        exp_rd = (!t.rw && !to) ? t.rd : mdl_rdata;
        chk("rdata_at_done", 64'(bus.init_rdata), 64'(exp_rd));
        mdl_rdata = exp_rd;
      end
      if (c < t.g) begin
        bus.bus_grant = 1'($urandom_range(0, 1));
        bus.bus_target_ready = bus.bus_grant ? 1'b0 : 1'($urandom_range(0, 1));
      end else begin
        bus.bus_grant = !(t.gdrop && c >= t.g + 4 && c <= t.g + 8);
        bus.bus_target_ready = 1'b1;
      end
      bus.bus_target_ack = (c == t.ack_c);
      bus.bus_data_in_valid = 1'b0;
      bus.bus_data_in = 1'($urandom_range(0, 1));
      if (t.junk && c >= t.g + 1 && c <= t.g + AW && (c % 2) == 1) bus.bus_data_in_valid = 1'b1;
      if (c >= w && c - w < 32 && ((t.vmask >> (c - w)) & 32'd1) != 0) begin
        bus.bus_data_in_valid = 1'b1;
        if (kk < DW) bus.bus_data_in = ((t.rd >> kk) & 8'd1) != 0;
        kk++;
      end
    end
    bus.bus_grant = 1'b0; bus.bus_target_ready = 1'b0;
    bus.bus_target_ack = 1'b0; bus.bus_data_in_valid = 1'b0;
  endtask

  initial begin
    int d_obs; logic err_obs; logic [7:0] rd_obs; txn_t t;
    // addr, wd, rw, g, gdrop, ack_c, vmask, junk, rd, exp_d, exp_err, exp_rdata
    tbl[0] = '{16'h4A32, 8'h9E, 1'b1,  0, 1'b0, 27, 32'h0000FFFF, 1'b0, 8'h00, 28, 1'b0, 8'h00};
    tbl[1] = '{16'h4A32, 8'h00, 1'b0,  0, 1'b0, 29, 32'h00001B6D, 1'b0, 8'h9E, 30, 1'b0, 8'h9E};
    tbl[2] = '{16'h00F0, 8'h00, 1'b0,  0, 1'b0,  5, 32'h000001FE, 1'b1, 8'h5A, 26, 1'b0, 8'h5A};
    tbl[3] = '{16'hA5A5, 8'h00, 1'b0,  0, 1'b0, 24, 32'h000000FF, 1'b0, 8'hC3, 25, 1'b0, 8'hC3};
    tbl[4] = '{16'h1234, 8'h5A, 1'b1, 20, 1'b1, 46, 32'h00000000, 1'b0, 8'h00, 47, 1'b0, 8'hC3};
    tbl[5] = '{16'hFFFF, 8'h00, 1'b1,  0, 1'b0, -1, 32'h00000000, 1'b0, 8'h00, 42, 1'b1, 8'hC3};
    tbl[6] = '{16'h0001, 8'h00, 1'b0,  2, 1'b0,  3, 32'h0000001F, 1'b0, 8'h77, 35, 1'b1, 8'hC3};
    tbl[7] = '{16'h8000, 8'h00, 1'b0,  0, 1'b0, 32, 32'h0000FF00, 1'b0, 8'h81, 33, 1'b0, 8'h81};

    bus.init_req = 1'b0; bus.init_addr = '0; bus.init_wdata = '0; bus.init_rw = 1'b0;
    bus.bus_grant = 1'b0; bus.bus_target_ready = 1'b0; bus.bus_target_ack = 1'b0;
    bus.bus_data_in = 1'b0; bus.bus_data_in_valid = 1'b0;

    #12;
    chk("reset_outputs", 64'(cur_vec()), 64'h100);
    chk("reset_rdata", 64'(bus.init_rdata), 64'h0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i], d_obs, err_obs, rd_obs);
      chk($sformatf("tbl%0d_done_cycle", i), 64'(d_obs), 64'(tbl[i].exp_d));
      chk($sformatf("tbl%0d_err", i), 64'(err_obs), 64'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_rdata", i), 64'(rd_obs), 64'(tbl[i].exp_rdata));
    end

    // async reset while address bit 5 of 0x4A32 (a 1) is on the bus
    @(negedge clk);
    bus.init_req = 1'b1; bus.init_addr = 16'h4A32; bus.init_wdata = 8'h9E; bus.init_rw = 1'b1;
    @(negedge clk);
    bus.init_req = 1'b0; bus.bus_grant = 1'b1; bus.bus_target_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("addr_bit5_before_reset", 64'(cur_vec()), 64'h0E8);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 64'(cur_vec()), 64'h100);
    chk("async_reset_rdata", 64'(bus.init_rdata), 64'h0);
    mdl_rdata = 8'h00;
    bus.bus_grant = 1'b0; bus.bus_target_ready = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    run_txn(tbl[0], d_obs, err_obs, rd_obs);
    chk("post_reset_done_cycle", 64'(d_obs), 64'd28);
    chk("post_reset_err", 64'(err_obs), 64'd0);

    for (int i = 0; i < 40; i++) begin
      t.addr = 16'($urandom); t.wd = 8'($urandom); t.rw = 1'($urandom_range(0, 1));
      t.g = $urandom_range(0, 5); t.gdrop = 1'($urandom_range(0, 1));
      t.ack_c = ($urandom_range(0, 7) == 0) ? -1 :
                $urandom_range(t.g + 1, wait_start(t) + TO + 2);
      t.vmask = $urandom | $urandom; t.junk = 1'($urandom_range(0, 1));
      t.rd = 8'($urandom);
      t.exp_d = 0; t.exp_err = 1'b0; t.exp_rdata = 8'h00;
      run_txn(t, d_obs, err_obs, rd_obs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/initiator_port.md
Name: initiator_port

Overview:
Initiator-side serial bus port: accepts one parallel read/write request from an initiator and serializes the address and write data onto the single-bit bus. For reads, it deserializes the returned read data. It is the counterpart of the target-side port. It sits between an initiator core and the bus arbiter/mux, and tracks target ready/ack to report completion, read data and timeout errors.

Parameters:
ADDR_WIDTH, 16, address field width (bits serialized LSB first)
DATA_WIDTH, 8, data field width (write and read)
TIMEOUT, 1024, max cycles waiting for ack/read data before aborting (>=1)

Ports:
clk  in  1  clock, all logic on posedge
rst_n  in  1  asynchronous, active-low reset
init_req  in  1  request valid; accepted when init_req && init_ready
init_addr  in  ADDR_WIDTH  request address
init_wdata  in  DATA_WIDTH  write data (ignored for reads)
init_rw  in  1  1=write, 0=read
init_ready  out  1  port idle, can accept request
init_done  out  1  one-cycle pulse, transaction finished
init_err  out  1  valid with init_done; 1=timeout abort
init_rdata  out  DATA_WIDTH  read data, valid with init_rdata_valid
init_rdata_valid  out  1  one-cycle pulse with init_done on successful read
bus_req  out  1  bus request to arbiter
bus_grant  in  1  arbiter grant
bus_data_out  out  1  serial address/write data bit
bus_data_out_valid  out  1  bus_data_out qualifier
bus_mode  out  1  0=address bits, 1=write data bits
bus_rw  out  1  direction to target, held for whole transaction
bus_data_in  in  1  serial read data bit from target
bus_data_in_valid  in  1  bus_data_in qualifier
bus_target_ready  in  1  target able to accept a transaction
bus_target_ack  in  1  target completion acknowledge

Behaviour:
- Reset (async, rst_n low): state IDLE. All registered outputs 0: init_done, init_err, init_rdata, init_rdata_valid, bus_req, bus_data_out, bus_data_out_valid, bus_mode, bus_rw. Counters and flags cleared. init_ready is a decode of state==IDLE, so it reads 1 during and after reset. Reset mid-transaction aborts immediately; no init_done is issued.
- All bus outputs and init_* outputs except init_ready are registered.
- States: IDLE, REQ, ADDR, GAP, WDATA, WAIT, DONE.
- IDLE: on init_req && init_ready, latch addr/wdata/rw. Next cycle: REQ, bus_req=1, bus_rw=latched rw.
- REQ: bus_req held. When bus_grant && bus_target_ready are sampled high, go to ADDR. No timeout applies in REQ.
- ADDR: exactly ADDR_WIDTH cycles with bus_data_out_valid=1, bus_mode=0, bus_data_out=addr[i] for i=0..ADDR_WIDTH-1 (LSB first). Then GAP if write, else WAIT.
- GAP: one cycle, bus_data_out_valid=0, bus_mode=0. Then WDATA.
- WDATA: exactly DATA_WIDTH cycles, valid=1, mode=1, data bits LSB first. Then WAIT with valid=0, mode=0.
- Once ADDR is entered, bus_grant is ignored; the transaction always runs to DONE or timeout.
- ack_seen flag: set on any cycle from the first ADDR cycle through WAIT where bus_target_ack=1; cleared in IDLE.
- Read capture: in WAIT for reads only, each cycle with bus_data_in_valid=1 stores bus_data_in into rdata[rx_cnt] (LSB first) and increments rx_cnt. Bits after DATA_WIDTH are ignored. Valid bits outside WAIT are ignored.
- WAIT exit:
  - write: ack_seen, or ack this cycle.
  - read: rx_cnt==DATA_WIDTH and ack_seen, in either order; a final bit and ack in the same cycle count.
  - Then go to DONE.
- Timeout: counter cleared on entering WAIT, increments each WAIT cycle. If the exit condition is not met after TIMEOUT WAIT cycles, go to DONE with error.
- DONE (one cycle):
  - init_done=1; bus_req=0; bus_rw=0.
  - init_err=1 on timeout.
  - For a successful read, init_rdata_valid=1 and init_rdata=captured byte.
  - On timeout, init_rdata_valid=0 and init_rdata is unchanged.
  - Next cycle IDLE. A new request may be accepted in the first IDLE cycle.
- init_rdata holds its last value until the next successful read.
- Minimum write latency, request accept to init_done: 1 (REQ) + ADDR_WIDTH + 1 + DATA_WIDTH + 1 (WAIT) + 1 cycles, with grant and ack immediate.

Test Plan:
- Write addr 0x4A32 data 0x9E, grant and target_ready high, ack 2 cycles after WDATA ends -> 16 address bits 0,1,0,0,1,1,0,0,0,1,0,1,0,0,1,0 with mode=0; 1 gap cycle; 8 data bits 0,1,1,1,1,0,0,1 with mode=1; bus_rw=1 throughout; init_done=1, init_err=0; bus_req drops in DONE.
- Read addr 0x4A32; target returns 0x9E serially with valid gaps, ack after last bit -> no GAP/WDATA cycles, bus_rw=0; init_rdata=0x9E, init_rdata_valid=1 together with init_done.
- Read with ack arriving during ADDR, before any data bits -> done only after the 8th bit; init_rdata correct. Also cover the last bit and ack in the same cycle.
- bus_grant withheld 20 cycles, then drop grant mid-ADDR -> no bus activity while in REQ with bus_req=1; after grant, the transfer completes unaffected by the grant drop.
- TIMEOUT=16, write with no ack -> init_done=1 and init_err=1 exactly 16 WAIT cycles after entry; init_rdata_valid=0; port returns to IDLE.
- Assert rst_n low at address bit 5 -> all outputs 0 asynchronously, init_ready=1; a subsequent request completes normally.
